// File: rtl/warmboot_seq.sv
// warmboot_seq: keyed warm-boot / BOOTSTS sequencer that owns the
// ICAPE2 bridge bus on behalf of the CPU.
//
// Ports:
//   i_clk, i_reset_n        clock, async active-low reset
//   i_wb_*  / o_wb_*        Wishbone slave (2-bit register select)
//                           0 CTRL/STATUS, 1 WBSTAR, 2 BOOTSTS, 3 zero
//   o_icap_* / i_icap_*     Wishbone master to the ICAPE2 bridge
//   o_busy                  sequencer not idle
//   o_err                   sticky transaction timeout
module warmboot_seq #(
    parameter logic [31:0] DEFAULT_WBSTAR = 32'h0000_0000,
    parameter int unsigned TIMEOUT_LG     = 12
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    output logic        o_icap_cyc,
    output logic        o_icap_stb,
    output logic        o_icap_we,
    output logic [4:0]  o_icap_addr,
    output logic [31:0] o_icap_data,
    input  logic        i_icap_ack,
    input  logic        i_icap_stall,
    input  logic [31:0] i_icap_data,
    output logic        o_busy,
    output logic        o_err
);

    localparam logic [15:0] KEY        = 16'hB007;
    localparam logic [4:0]  REG_WBSTAR = 5'h10;
    localparam logic [4:0]  REG_CMD    = 5'h04;
    localparam logic [4:0]  REG_BOOTST = 5'h16;
    localparam logic [31:0] CMD_IPROG  = 32'h0000_000F;

    // One short of all-ones: the counter reaches all-ones on the
    // same edge that the sequencer gives up.
    localparam logic [TIMEOUT_LG-1:0] TMO_LAST =
        {{(TIMEOUT_LG-1){1'b1}}, 1'b0};

    typedef enum logic [3:0] {
        S_IDLE,
        S_WSTAR_REQ,
        S_WSTAR_WAIT,
        S_GAP,
        S_IPROG_REQ,
        S_IPROG_WAIT,
        S_HALT,
        S_RD_REQ,
        S_RD_WAIT
    } state_t;

    state_t state, state_d;

    logic [TIMEOUT_LG-1:0] tmo_cnt;
    logic [31:0] wbstar;
    logic [31:0] bootsts;
    logic        err;
    logic        active;
    logic        tmo_hit;
    logic        bootsts_ld;

    logic        bus_req;
    logic        bus_wr;
    logic        ctrl_wr;
    logic        idle;
    logic        halted;
    logic        go;
    logic        rdsts;
    logic        clrerr;
    logic [31:0] rd_mux;

    assign bus_req = i_wb_cyc & i_wb_stb;
    assign bus_wr  = bus_req & i_wb_we;
    assign ctrl_wr = bus_wr && (i_wb_addr == 2'd0)
                     && (i_wb_data[31:16] == KEY);
    assign idle    = (state == S_IDLE);
    assign halted  = (state == S_HALT);
    assign go      = ctrl_wr & idle & i_wb_data[0];
    assign rdsts   = ctrl_wr & idle & i_wb_data[1] & ~i_wb_data[0];
    assign clrerr  = ctrl_wr & i_wb_data[2];

    assign o_busy     = ~idle;
    assign o_err      = err;
    assign o_wb_stall = 1'b0;

    always_comb begin
        rd_mux = 32'h0;
        unique case (i_wb_addr)
            2'd0: rd_mux = {29'h0, halted, err, ~idle};
            2'd1: rd_mux = wbstar;
            2'd2: rd_mux = bootsts;
            default: rd_mux = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state;
        o_icap_cyc  = 1'b0;
        o_icap_stb  = 1'b0;
        o_icap_we   = 1'b0;
        o_icap_addr = 5'h0;
        o_icap_data = 32'h0;
        active      = 1'b0;
        tmo_hit     = 1'b0;
        bootsts_ld  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (go)
                    state_d = S_WSTAR_REQ;
                else if (rdsts)
                    state_d = S_RD_REQ;
            end
            S_WSTAR_REQ: begin
                active      = 1'b1;
                o_icap_cyc  = 1'b1;
                o_icap_stb  = 1'b1;
                o_icap_we   = 1'b1;
                o_icap_addr = REG_WBSTAR;
                o_icap_data = wbstar;
                if (!i_icap_stall)
                    state_d = S_WSTAR_WAIT;
            end
            S_WSTAR_WAIT: begin
                active     = 1'b1;
                o_icap_cyc = 1'b1;
                if (i_icap_ack)
                    state_d = S_GAP;
            end
            // Guarantees a cyc-low cycle between the two writes.
            S_GAP: state_d = S_IPROG_REQ;
            S_IPROG_REQ: begin
                active      = 1'b1;
                o_icap_cyc  = 1'b1;
                o_icap_stb  = 1'b1;
                o_icap_we   = 1'b1;
                o_icap_addr = REG_CMD;
                o_icap_data = CMD_IPROG;
                if (!i_icap_stall)
                    state_d = S_IPROG_WAIT;
            end
            S_IPROG_WAIT: begin
                active     = 1'b1;
                o_icap_cyc = 1'b1;
                if (i_icap_ack)
                    state_d = S_HALT;
            end
            // The FPGA reconfigures from here; only reset leaves.
            S_HALT: state_d = S_HALT;
            S_RD_REQ: begin
                active      = 1'b1;
                o_icap_cyc  = 1'b1;
                o_icap_stb  = 1'b1;
                o_icap_addr = REG_BOOTST;
                if (!i_icap_stall)
                    state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                active     = 1'b1;
                o_icap_cyc = 1'b1;
                if (i_icap_ack) begin
                    bootsts_ld = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Timeout beats a same-cycle ack.
        if (active && (tmo_cnt == TMO_LAST)) begin
            tmo_hit    = 1'b1;
            bootsts_ld = 1'b0;
            state_d    = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= S_IDLE;
            tmo_cnt <= '0;
        end else begin
            state <= state_d;
            // Every REQ is entered from a non-active state, so the
            // counter is already zero on entry.
            if (active)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            err     <= 1'b0;
            wbstar  <= DEFAULT_WBSTAR;
            bootsts <= 32'h0;
        end else begin
            if (tmo_hit)
                err <= 1'b1;
            else if (clrerr)
                err <= 1'b0;
            if (bus_wr && (i_wb_addr == 2'd1) && idle)
                wbstar <= i_wb_data;
            if (bootsts_ld)
                bootsts <= i_icap_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= 32'h0;
        end else begin
            o_wb_ack  <= bus_req;
            o_wb_data <= (bus_req && !i_wb_we) ? rd_mux : 32'h0;
        end
    end

endmodule

// File: tb/tb_warmboot_seq.sv
// tb_warmboot_seq: directed bench for warmboot_seq with a simple
// stalling/acking ICAPE2 bridge model.
module tb_warmboot_seq;

    logic clk;
    logic rst_n;
    logic cyc_a, cyc_b, wb_stb, wb_we;
    logic [1:0]  wb_addr;
    logic [31:0] wb_wdata;

    logic        a_ack, a_stall, a_icyc, a_istb, a_iwe;
    logic [31:0] a_rdata, a_idata;
    logic [4:0]  a_iaddr;
    logic        a_busy, a_err;
    logic        b_ack, b_stall, b_icyc, b_istb, b_iwe;
    logic [31:0] b_rdata, b_idata;
    logic [4:0]  b_iaddr;
    logic        b_busy, b_err;

    // bridge model controls (written by main sequence)
    int          m_stall_n, m_ack_n;
    logic [31:0] m_rdata;
    logic        m_manual, man_ack, man_stall;
    // bridge model state (written by model only)
    logic        m_ack, m_stall, prev_cyc, pending;
    int          stall_cnt, wait_cnt;
    int          stb_cycles, cyc_rises, ack_cyc_bad, log_n;
    logic [4:0]  log_addr [32];
    logic [31:0] log_data [32];
    logic        log_we   [32];

    logic icap_ack, icap_stall;
    assign icap_ack   = m_manual ? man_ack : m_ack;
    assign icap_stall = m_manual ? man_stall : m_stall;

    int checks, failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    warmboot_seq #(
        .DEFAULT_WBSTAR(32'hA5A5_0000),
        .TIMEOUT_LG(12)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_cyc(cyc_a), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_wdata),
        .o_wb_ack(a_ack), .o_wb_stall(a_stall), .o_wb_data(a_rdata),
        .o_icap_cyc(a_icyc), .o_icap_stb(a_istb), .o_icap_we(a_iwe),
        .o_icap_addr(a_iaddr), .o_icap_data(a_idata),
        .i_icap_ack(icap_ack), .i_icap_stall(icap_stall),
        .i_icap_data(m_rdata),
        .o_busy(a_busy), .o_err(a_err)
    );

    warmboot_seq #(
        .DEFAULT_WBSTAR(32'h0000_0000),
        .TIMEOUT_LG(4)
    ) dut_t (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_wb_cyc(cyc_b), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_addr(wb_addr), .i_wb_data(wb_wdata),
        .o_wb_ack(b_ack), .o_wb_stall(b_stall), .o_wb_data(b_rdata),
        .o_icap_cyc(b_icyc), .o_icap_stb(b_istb), .o_icap_we(b_iwe),
        .o_icap_addr(b_iaddr), .o_icap_data(b_idata),
        .i_icap_ack(1'b0), .i_icap_stall(1'b0),
        .i_icap_data(32'h0),
        .o_busy(b_busy), .o_err(b_err)
    );

    // Bridge model: decides stall/ack at each negedge for the next edge.
    initial begin
        m_ack = 1'b0; m_stall = 1'b0; prev_cyc = 1'b0; pending = 1'b0;
        stall_cnt = 0; wait_cnt = 0;
        stb_cycles = 0; cyc_rises = 0; ack_cyc_bad = 0; log_n = 0;
        forever begin
            @(negedge clk);
            if (m_ack && a_icyc) ack_cyc_bad++;
            if (a_icyc && !prev_cyc) cyc_rises++;
            prev_cyc = a_icyc;
            if (a_icyc && a_istb) stb_cycles++;
            if (!a_icyc) begin
                stall_cnt = 0; wait_cnt = 0; pending = 1'b0;
                m_ack = 1'b0; m_stall = 1'b0;
            end else if (a_istb) begin
                m_ack = 1'b0;
                if (stall_cnt < m_stall_n) begin
                    m_stall = 1'b1;
                    stall_cnt++;
                end else begin
                    m_stall = 1'b0;
                    if (!pending && log_n < 32) begin
                        log_addr[log_n] = a_iaddr;
                        log_data[log_n] = a_idata;
                        log_we[log_n]   = a_iwe;
                        log_n++;
                    end
                    pending  = 1'b1;
                    wait_cnt = 0;
                end
            end else if (pending) begin
                wait_cnt++;
                if (wait_cnt >= m_ack_n) begin
                    m_ack   = 1'b1;
                    pending = 1'b0;
                end else begin
                    m_ack = 1'b0;
                end
            end else begin
                m_ack = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input bit b, input logic we,
                        input logic [1:0] a, input logic [31:0] d,
                        output logic ack, output logic [31:0] rd);
        @(negedge clk);
        if (b) cyc_b = 1'b1;
        else   cyc_a = 1'b1;
        wb_stb = 1'b1; wb_we = we; wb_addr = a; wb_wdata = d;
        @(posedge clk);
        #1;
        ack = b ? b_ack : a_ack;
        rd  = b ? b_rdata : a_rdata;
        cyc_a = 1'b0; cyc_b = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_wr(input bit b, input logic [1:0] a,
                         input logic [31:0] d, input string tag);
        logic ack;
        logic [31:0] rd;
        xfer(b, 1'b1, a, d, ack, rd);
        chk({tag, "_ack"}, 32'(ack), 1);
    endtask

    task automatic wb_rd(input bit b, input logic [1:0] a,
                         input logic [31:0] exp, input string tag);
        logic ack;
        logic [31:0] rd;
        xfer(b, 1'b0, a, 32'h0, ack, rd);
        chk({tag, "_ack"}, 32'(ack), 1);
        chk(tag, rd, exp);
    endtask

    task automatic wait_idle(input int n);
        for (int i = 0; i < n && a_busy; i++) @(negedge clk);
    endtask

    int base, sb, cr, ab, n;

    initial begin
        checks = 0; failures = 0;
        cyc_a = 0; cyc_b = 0; wb_stb = 0; wb_we = 0;
        wb_addr = 2'd0; wb_wdata = 32'h0;
        m_stall_n = 0; m_ack_n = 1; m_rdata = 32'h0;
        m_manual = 1'b0; man_ack = 1'b0; man_stall = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_icyc", 32'(a_icyc), 0);
        chk("rst_istb", 32'(a_istb), 0);
        chk("rst_wback", 32'(a_ack), 0);
        chk("rst_wbdata", a_rdata, 0);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_err", 32'(a_err), 0);
        chk("rst_t_icyc", 32'(b_icyc), 0);
        rst_n = 1'b1;

        wb_rd(0, 2'd0, 32'h0, "rd_ctrl");
        wb_rd(0, 2'd1, 32'hA5A5_0000, "rd_wbstar_rst");
        wb_rd(0, 2'd2, 32'h0, "rd_bootsts_rst");
        wb_wr(0, 2'd3, 32'hFFFF_FFFF, "wr_addr3");
        wb_rd(0, 2'd3, 32'h0, "rd_addr3");
        chk("stall", 32'(a_stall), 0);
        chk("t_stall", 32'(b_stall), 0);

        // bad key
        wb_wr(0, 2'd0, 32'h1234_0001, "badkey");
        chk("badkey_icyc", 32'(a_icyc), 0);
        chk("badkey_busy", 32'(a_busy), 0);
        repeat (3) @(negedge clk);
        chk("badkey_busy_later", 32'(a_busy), 0);

        // BOOTSTS read
        m_stall_n = 2; m_ack_n = 3; m_rdata = 32'h0000_0102;
        base = log_n; sb = stb_cycles;
        wb_wr(0, 2'd0, 32'hB007_0002, "rdsts");
        chk("rdsts_icyc", 32'(a_icyc), 1);
        chk("rdsts_istb", 32'(a_istb), 1);
        chk("rdsts_iwe", 32'(a_iwe), 0);
        chk("rdsts_iaddr", 32'(a_iaddr), 'h16);
        chk("rdsts_busy", 32'(a_busy), 1);
        wait_idle(200);
        chk("rdsts_done", 32'(a_busy), 0);
        chk("rdsts_ntx", log_n - base, 1);
        chk("rdsts_txaddr", 32'(log_addr[base]), 'h16);
        chk("rdsts_txwe", 32'(log_we[base]), 0);
        chk("rdsts_stb_cyc", stb_cycles - sb, 3);
        wb_rd(0, 2'd2, 32'h0000_0102, "rdsts_val");
        wb_rd(0, 2'd0, 32'h0, "rdsts_ctrl");

        // busy lockout
        m_ack_n = 30; m_rdata = 32'h0000_0055;
        base = log_n;
        wb_wr(0, 2'd0, 32'hB007_0002, "lk_rdsts");
        chk("lk_busy", 32'(a_busy), 1);
        wb_wr(0, 2'd1, 32'hDEAD_BEEF, "lk_wbstar");
        wb_wr(0, 2'd0, 32'hB007_0001, "lk_go");
        wb_rd(0, 2'd0, 32'h1, "lk_status");
        wait_idle(200);
        chk("lk_done", 32'(a_busy), 0);
        repeat (3) @(negedge clk);
        chk("lk_no_reboot", 32'(a_busy), 0);
        chk("lk_no_icyc", 32'(a_icyc), 0);
        chk("lk_ntx", log_n - base, 1);
        wb_rd(0, 2'd1, 32'hA5A5_0000, "lk_wbstar_kept");
        wb_rd(0, 2'd2, 32'h0000_0055, "lk_bootsts");

        // timeout on TIMEOUT_LG=4 instance
        wb_wr(1, 2'd0, 32'hB007_0001, "t_go");
        chk("t_icyc", 32'(b_icyc), 1);
        chk("t_istb", 32'(b_istb), 1);
        chk("t_iwe", 32'(b_iwe), 1);
        chk("t_iaddr", 32'(b_iaddr), 'h10);
        chk("t_idata", b_idata, 0);
        n = 1;
        for (int i = 0; i < 100 && b_icyc; i++) begin
            @(posedge clk);
            #1;
            if (b_icyc) n++;
        end
        chk("t_cyc_len", n, 15);
        chk("t_err", 32'(b_err), 1);
        chk("t_busy", 32'(b_busy), 0);
        wb_rd(1, 2'd0, 32'h2, "t_status");
        wb_wr(1, 2'd0, 32'h0000_0004, "t_clr_nokey");
        chk("t_err_kept", 32'(b_err), 1);
        wb_wr(1, 2'd0, 32'hB007_0004, "t_clr");
        chk("t_err_clr", 32'(b_err), 0);
        wb_rd(1, 2'd0, 32'h0, "t_status_clr");

        // keyed reboot
        m_stall_n = 7; m_ack_n = 200;
        wb_wr(0, 2'd1, 32'h0040_0000, "rb_wbstar");
        wb_rd(0, 2'd1, 32'h0040_0000, "rb_wbstar_rd");
        base = log_n; sb = stb_cycles; cr = cyc_rises; ab = ack_cyc_bad;
        wb_wr(0, 2'd0, 32'hB007_0001, "rb_go");
        chk("rb_icyc", 32'(a_icyc), 1);
        chk("rb_istb", 32'(a_istb), 1);
        chk("rb_iwe", 32'(a_iwe), 1);
        chk("rb_iaddr", 32'(a_iaddr), 'h10);
        chk("rb_idata", a_idata, 32'h0040_0000);
        for (int i = 0; i < 2000 && !((log_n - base) == 2 && !a_icyc); i++)
            @(negedge clk);
        chk("rb_ntx", log_n - base, 2);
        chk("rb_tx0_addr", 32'(log_addr[base]), 'h10);
        chk("rb_tx0_data", log_data[base], 32'h0040_0000);
        chk("rb_tx0_we", 32'(log_we[base]), 1);
        chk("rb_tx1_addr", 32'(log_addr[base+1]), 'h04);
        chk("rb_tx1_data", log_data[base+1], 32'h0000_000F);
        chk("rb_tx1_we", 32'(log_we[base+1]), 1);
        chk("rb_stb_cyc", stb_cycles - sb, 16);
        chk("rb_cyc_rises", cyc_rises - cr, 2);
        chk("rb_cyc_after_ack", ack_cyc_bad - ab, 0);
        chk("rb_icyc_end", 32'(a_icyc), 0);
        repeat (5) @(negedge clk);
        chk("rb_halt_busy", 32'(a_busy), 1);
        wb_rd(0, 2'd0, 32'h5, "rb_halt_status");
        wb_wr(0, 2'd0, 32'hB007_0001, "rb_go_in_halt");
        repeat (2) @(negedge clk);
        chk("rb_halt_icyc", 32'(a_icyc), 0);

        // reset mid-transaction
        m_manual = 1'b1; man_stall = 1'b0; man_ack = 1'b0;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        chk("rm_busy0", 32'(a_busy), 0);
        wb_wr(0, 2'd0, 32'hB007_0001, "rm_go");
        chk("rm_icyc", 32'(a_icyc), 1);
        @(posedge clk);
        @(negedge clk);
        chk("rm_wait_icyc", 32'(a_icyc), 1);
        chk("rm_wait_istb", 32'(a_istb), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_icyc_async", 32'(a_icyc), 0);
        chk("rm_istb_async", 32'(a_istb), 0);
        chk("rm_iwe_async", 32'(a_iwe), 0);
        chk("rm_iaddr_async", 32'(a_iaddr), 0);
        chk("rm_idata_async", a_idata, 0);
        chk("rm_busy_async", 32'(a_busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rm_late_ack_busy", 32'(a_busy), 0);
        chk("rm_late_ack_icyc", 32'(a_icyc), 0);
        chk("rm_err", 32'(a_err), 0);
        wb_rd(0, 2'd1, 32'hA5A5_0000, "rm_wbstar");
        wb_rd(0, 2'd2, 32'h0, "rm_bootsts");
        wb_rd(0, 2'd0, 32'h0, "rm_ctrl");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
